// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths and types for the register file writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  // r0 is hardwired to zero; writes to it are never committed
  localparam reg_addr_t ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant logic with a one-bit priority
//               pointer. Grants are suppressed while reset is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection: a lone requester always wins, the pointer breaks ties
  always_comb begin
    grant_o = 2'b00;
    if (!rst) begin
      if (valid_i == 2'b11) begin
        grant_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant_o = valid_i;
      end
    end
  end

  // After any grant, the other requester gets priority next time
  always_comb begin
    ptr_d = ptr_q;
    if (grant_o[0]) begin
      ptr_d = 1'b1;
    end else if (grant_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register, req0 favoured out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file write port between the ALU pipe
//               (req0) and the mul/div/load unit (req1), registers the chosen
//               write, and tracks pending destination registers for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rw,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rw,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              writeEn,
  output logic [ADDR_W-1:0] rw,
  output logic [DATA_W-1:0] busW,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_rd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic              busy_a,
  output logic              busy_b
);

  logic [1:0]          grant;
  logic                hs;
  logic [ADDR_W-1:0]   sel_rw;
  logic [DATA_W-1:0]   sel_data;

  logic                writeEn_q, writeEn_d;
  logic [ADDR_W-1:0]   rw_q, rw_d;
  logic [DATA_W-1:0]   busW_q, busW_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i ({req1_valid, req0_valid}),
    .grant_o (grant)
  );

  // Grant only goes to a valid requester, so any grant is a handshake
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign hs         = |grant;
  assign sel_rw     = grant[1] ? req1_rw   : req0_rw;
  assign sel_data   = grant[1] ? req1_data : req0_data;

  // Next write-port value: load on handshake, never enable a write to r0
  always_comb begin
    writeEn_d = 1'b0;
    rw_d      = rw_q;
    busW_d    = busW_q;
    if (hs) begin
      writeEn_d = (sel_rw != ADDR_W'(ZERO_REG));
      rw_d      = sel_rw;
      busW_d    = sel_data;
    end
  end

  // Pending-write scoreboard: clear on writeback, then set, so a new issue wins
  always_comb begin
    sb_d = sb_q;
    if (hs) begin
      sb_d[sel_rw] = 1'b0;
    end
    if (sb_set && (sb_rd != ADDR_W'(ZERO_REG))) begin
      sb_d[sb_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Write-port and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      writeEn_q <= 1'b0;
      rw_q      <= '0;
      busW_q    <= '0;
      sb_q      <= '0;
    end else begin
      writeEn_q <= writeEn_d;
      rw_q      <= rw_d;
      busW_q    <= busW_d;
      sb_q      <= sb_d;
    end
  end

  assign writeEn = writeEn_q;
  assign rw      = rw_q;
  assign busW    = busW_q;
  assign busy_a  = sb_q[ra];
  assign busy_b  = sb_q[rb];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A reference model
//               tracks pointer and pending bits; committed writes are queued
//               and matched against the register file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rw, req1_rw;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        writeEn;
  logic [4:0]  rw;
  logic [31:0] busW;
  logic        sb_set;
  logic [4:0]  sb_rd, ra, rb;
  logic        busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  // reference model state
  logic        m_ptr;
  logic        m_we;
  logic [4:0]  m_rw;
  logic [31:0] m_bus;
  logic [31:0] m_sb;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_rw    (req0_rw),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rw    (req1_rw),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .writeEn    (writeEn),
    .rw         (rw),
    .busW       (busW),
    .sb_set     (sb_set),
    .sb_rd      (sb_rd),
    .ra         (ra),
    .rb         (rb),
    .busy_a     (busy_a),
    .busy_b     (busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model at posedge
  task automatic step(input logic r,
                      input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic s, input logic [4:0] sd,
                      input logic [4:0] xa, input logic [4:0] xb);
    logic g0, g1;
    logic [4:0]  w_rw;
    logic [31:0] w_d;
    wr_t e;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_rw = a0; req0_data = d0;
    req1_valid = v1; req1_rw = a1; req1_data = d1;
    sb_set = s; sb_rd = sd; ra = xa; rb = xb;
    #1;
    g0 = !r && v0 && (!v1 || (m_ptr == 1'b0));
    g1 = !r && v1 && (!v0 || (m_ptr == 1'b1));
    check("req0_ready", {63'd0, req0_ready}, {63'd0, g0});
    check("req1_ready", {63'd0, req1_ready}, {63'd0, g1});
    check("busy_a", {63'd0, busy_a}, {63'd0, m_sb[xa]});
    check("busy_b", {63'd0, busy_b}, {63'd0, m_sb[xb]});
    check("writeEn", {63'd0, writeEn}, {63'd0, m_we});
    check("rw_hold", {59'd0, rw}, {59'd0, m_rw});
    check("busW_hold", {32'd0, busW}, {32'd0, m_bus});
    if (m_we) begin
      if (exp_q.size() == 0) begin
        check("sb_queue_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_rw", {59'd0, rw}, {59'd0, e.rw});
        check("sb_busW", {32'd0, busW}, {32'd0, e.data});
      end
    end
    @(posedge clk);
    if (r) begin
      m_ptr = 1'b0; m_we = 1'b0; m_rw = '0; m_bus = '0; m_sb = '0;
    end else begin
      w_rw = g1 ? a1 : a0;
      w_d  = g1 ? d1 : d0;
      m_we = (g0 || g1) && (w_rw != 5'd0);
      if (g0 || g1) begin
        m_rw  = w_rw;
        m_bus = w_d;
        m_sb[w_rw] = 1'b0;
        if (w_rw != 5'd0) exp_q.push_back('{rw: w_rw, data: w_d});
      end
      if (g0) m_ptr = 1'b1;
      else if (g1) m_ptr = 1'b0;
      if (s && sd != 5'd0) m_sb[sd] = 1'b1;
      m_sb[0] = 1'b0;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] xa, input logic [4:0] xb);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, xa, xb);
  endtask

  initial begin
    m_ptr = 0; m_we = 0; m_rw = 0; m_bus = 0; m_sb = 0;
    rst = 1; req0_valid = 0; req1_valid = 0; req0_rw = 0; req1_rw = 0;
    req0_data = 0; req1_data = 0; sb_set = 0; sb_rd = 0; ra = 0; rb = 0;

    // reset then idle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    idle(2, 5, 5);
    check("reset_writeEn", {63'd0, writeEn}, 64'd0);
    check("reset_rw", {59'd0, rw}, 64'd0);

    // req0 alone
    step(0, 1, 3, 32'h1234, 0, 0, 0, 0, 0, 5, 5);
    idle(2, 5, 5);

    // contention for 4 cycles: strict alternation
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 32'hA000 + i, 1, 2, 32'hB000 + i, 0, 0, 5, 5);
    idle(2, 5, 5);

    // scoreboard set, busy until req1 writes r7
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 6);
    idle(2, 7, 6);
    check("busy7_pending", {63'd0, busy_a}, 64'd1);
    step(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 6);
    idle(1, 7, 6);
    // set and clear of r7 in the same cycle: set wins
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
    step(0, 0, 0, 0, 1, 7, 32'h78, 1, 7, 7, 7);
    idle(1, 7, 7);
    check("busy7_setwins", {63'd0, busy_a}, 64'd1);
    step(0, 1, 7, 32'h79, 0, 0, 0, 0, 0, 7, 7);
    idle(1, 7, 7);

    // r0 write: consumed, no writeEn, pointer advances
    step(0, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0);
    step(0, 1, 5, 32'h55, 1, 6, 32'h66, 1, 0, 0, 0);
    idle(2, 0, 0);

    // reset during a handshake with bit 9 pending
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    step(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 9);
    step(0, 1, 10, 32'hAA, 1, 11, 32'hBB, 0, 0, 9, 9);
    idle(2, 9, 9);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(3, 0, 0);
    check("sb_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
